// File: rtl/ram_arbiter_if.sv
// Bus bundle for ram_arbiter: two command requesters (A = SPI slave, B = local
// host), the RAM command/return path and the status flags.
interface ram_arbiter_if;
    logic       a_valid;
    logic [9:0] a_din;
    logic       a_ready;
    logic [7:0] a_dout;
    logic       a_dout_valid;

    logic       b_valid;
    logic [9:0] b_din;
    logic       b_ready;
    logic [7:0] b_dout;
    logic       b_dout_valid;

    logic       ram_rx_valid;
    logic [9:0] ram_din;
    logic       ram_tx_valid;
    logic [7:0] ram_dout;

    logic       busy;
    logic       timeout_err;

    // Arbiter side.
    modport slave (
        input  a_valid, a_din, b_valid, b_din, ram_tx_valid, ram_dout,
        output a_ready, a_dout, a_dout_valid,
               b_ready, b_dout, b_dout_valid,
               ram_rx_valid, ram_din, busy, timeout_err
    );

    // Requester / RAM side.
    modport master (
        output a_valid, a_din, b_valid, b_din, ram_tx_valid, ram_dout,
        input  a_ready, a_dout, a_dout_valid,
               b_ready, b_dout, b_dout_valid,
               ram_rx_valid, ram_din, busy, timeout_err
    );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter in front of a single RAM command port. A requester that
// starts an address phase or a read owns the RAM until it finishes or times out.
module ram_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input logic          clk,
    input logic          rst_n,
    ram_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOCKED,
        ST_WAIT_RD
    } state_t;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_t;

    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

    state_t     state_q, state_d;
    req_t       owner_q, owner_d;
    req_t       last_grant_q, last_grant_d;
    logic [7:0] idle_cnt_q, idle_cnt_d;

    logic       ram_rx_valid_q, ram_rx_valid_d;
    logic [9:0] ram_din_q, ram_din_d;
    logic [7:0] a_dout_q, a_dout_d;
    logic [7:0] b_dout_q, b_dout_d;
    logic       a_dout_valid_q, a_dout_valid_d;
    logic       b_dout_valid_q, b_dout_valid_d;
    logic       timeout_err_q, timeout_err_d;

    logic       a_grant, b_grant;
    logic       xfer_a, xfer_b, xfer;
    req_t       xfer_who;
    logic [9:0] xfer_word;
    logic [1:0] xfer_cmd;
    logic       idle_tick;

    // In IDLE a tie goes to whoever was not granted last.
    always_comb begin
        a_grant = 1'b0;
        b_grant = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (bus.a_valid && (!bus.b_valid || last_grant_q == REQ_B)) begin
                    a_grant = 1'b1;
                end else if (bus.b_valid) begin
                    b_grant = 1'b1;
                end
            end
            ST_LOCKED: begin
                a_grant = (owner_q == REQ_A);
                b_grant = (owner_q == REQ_B);
            end
            default: ;
        endcase
    end

    assign xfer_a    = bus.a_valid && a_grant;
    assign xfer_b    = bus.b_valid && b_grant;
    assign xfer      = xfer_a || xfer_b;
    assign xfer_who  = xfer_b ? REQ_B : REQ_A;
    assign xfer_word = xfer_b ? bus.b_din : bus.a_din;
    assign xfer_cmd  = xfer_word[9:8];

    // NOTE: every variable gets a default at the top of the block so no path
    // through the case leaves one unassigned and infers a latch.
    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_grant_d   = last_grant_q;
        idle_cnt_d     = idle_cnt_q;
        ram_rx_valid_d = xfer;
        ram_din_d      = xfer ? xfer_word : ram_din_q;
        a_dout_d       = a_dout_q;
        b_dout_d       = b_dout_q;
        a_dout_valid_d = 1'b0;
        b_dout_valid_d = 1'b0;
        timeout_err_d  = 1'b0;
        idle_tick      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (xfer) begin
                    last_grant_d = xfer_who;
                    idle_cnt_d   = '0;
                    if (xfer_cmd == CMD_RD_DATA) begin
                        owner_d = xfer_who;
                        state_d = ST_WAIT_RD;
                    end else if (xfer_cmd != CMD_WR_DATA) begin
                        owner_d = xfer_who;
                        state_d = ST_LOCKED;
                    end
                end
            end

            ST_LOCKED: begin
                if (xfer) begin
                    idle_cnt_d = '0;
                    if (xfer_cmd == CMD_WR_DATA) begin
                        state_d = ST_IDLE;
                    end else if (xfer_cmd == CMD_RD_DATA) begin
                        state_d = ST_WAIT_RD;
                    end
                end else begin
                    idle_tick = 1'b1;
                end
            end

            ST_WAIT_RD: begin
                if (bus.ram_tx_valid) begin
                    state_d    = ST_IDLE;
                    idle_cnt_d = '0;
                    if (owner_q == REQ_A) begin
                        a_dout_d       = bus.ram_dout;
                        a_dout_valid_d = 1'b1;
                    end else begin
                        b_dout_d       = bus.ram_dout;
                        b_dout_valid_d = 1'b1;
                    end
                end else begin
                    idle_tick = 1'b1;
                end
            end

            default: state_d = ST_IDLE;
        endcase

        // A cycle with no owner progress either counts up or, on the TIMEOUT-th
        // such cycle, drops the lock.
        if (idle_tick) begin
            if (idle_cnt_q == TIMEOUT_LAST) begin
                state_d       = ST_IDLE;
                idle_cnt_d    = '0;
                timeout_err_d = 1'b1;
            end else begin
                idle_cnt_d = idle_cnt_q + 8'd1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            owner_q        <= REQ_A;
            last_grant_q   <= REQ_B;
            idle_cnt_q     <= '0;
            ram_rx_valid_q <= 1'b0;
            ram_din_q      <= '0;
            a_dout_q       <= '0;
            b_dout_q       <= '0;
            a_dout_valid_q <= 1'b0;
            b_dout_valid_q <= 1'b0;
            timeout_err_q  <= 1'b0;
        end else begin
            state_q        <= state_d;
            owner_q        <= owner_d;
            last_grant_q   <= last_grant_d;
            idle_cnt_q     <= idle_cnt_d;
            ram_rx_valid_q <= ram_rx_valid_d;
            ram_din_q      <= ram_din_d;
            a_dout_q       <= a_dout_d;
            b_dout_q       <= b_dout_d;
            a_dout_valid_q <= a_dout_valid_d;
            b_dout_valid_q <= b_dout_valid_d;
            timeout_err_q  <= timeout_err_d;
        end
    end

    assign bus.a_ready      = a_grant;
    assign bus.b_ready      = b_grant;
    assign bus.ram_rx_valid = ram_rx_valid_q;
    assign bus.ram_din      = ram_din_q;
    assign bus.a_dout       = a_dout_q;
    assign bus.b_dout       = b_dout_q;
    assign bus.a_dout_valid = a_dout_valid_q;
    assign bus.b_dout_valid = b_dout_valid_q;
    assign bus.busy         = (state_q != ST_IDLE);
    assign bus.timeout_err  = timeout_err_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed vector table, hand-written
// timeout/reset sequences and random traffic against a transaction-level model.
module tb_ram_arbiter;

    localparam int TO = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    ram_arbiter_if bus ();

    ram_arbiter #(.TIMEOUT(TO)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: who holds the RAM (0 free, 1 locked, 2 read pending), for whom,
    // who won the last free-for-all, and how many idle cycles have passed.
    int         m_mode, m_owner, m_last, m_idle;
    logic       e_rx_v, e_adv, e_bdv, e_err;
    logic [9:0] e_din;
    logic [7:0] e_adout, e_bdout;

    function automatic void model_reset();
        m_mode  = 0;
        m_owner = 0;
        m_last  = 1;
        m_idle  = 0;
        e_rx_v  = 1'b0;
        e_din   = '0;
        e_adv   = 1'b0;
        e_bdv   = 1'b0;
        e_adout = '0;
        e_bdout = '0;
        e_err   = 1'b0;
    endfunction

    function automatic void model_ready(input logic av, input logic bv,
                                        output logic ar, output logic br);
        ar = 1'b0;
        br = 1'b0;
        if (m_mode == 0) begin
            if (av && bv) begin
                ar = (m_last == 1);
                br = (m_last == 0);
            end else begin
                ar = av;
                br = bv;
            end
        end else if (m_mode == 1) begin
            ar = (m_owner == 0);
            br = (m_owner == 1);
        end
    endfunction

    function automatic void model_update(input logic av, input logic [9:0] ad,
                                         input logic bv, input logic [9:0] bd,
                                         input logic tv, input logic [7:0] td,
                                         input logic ar, input logic br);
        logic       xa, xb;
        logic [9:0] w;
        int         kind, who;
        bit         stalled;
        xa      = av && ar;
        xb      = bv && br;
        w       = xb ? bd : ad;
        who     = xb ? 1 : 0;
        kind    = int'(w[9:8]);
        stalled = 1'b0;
        e_rx_v  = xa || xb;
        if (e_rx_v) e_din = w;
        e_adv = 1'b0;
        e_bdv = 1'b0;
        e_err = 1'b0;
        case (m_mode)
            0: if (e_rx_v) begin
                m_last = who;
                if (kind != 1) begin
                    m_owner = who;
                    m_mode  = (kind == 3) ? 2 : 1;
                    m_idle  = 0;
                end
            end
            1: if (e_rx_v) begin
                m_idle = 0;
                if (kind == 1) m_mode = 0;
                else if (kind == 3) m_mode = 2;
            end else stalled = 1'b1;
            default: if (tv) begin
                if (m_owner == 0) begin e_adout = td; e_adv = 1'b1; end
                else begin e_bdout = td; e_bdv = 1'b1; end
                m_mode = 0;
                m_idle = 0;
            end else stalled = 1'b1;
        endcase
        if (stalled) begin
            m_idle++;
            if (m_idle >= TO) begin
                m_mode = 0;
                m_idle = 0;
                e_err  = 1'b1;
            end
        end
    endfunction

    // One clock: drive at the falling edge, compare everything 1 time unit later,
    // then advance the model past the coming rising edge.
    task automatic step(input logic av, input logic [9:0] ad,
                        input logic bv, input logic [9:0] bd,
                        input logic tv, input logic [7:0] td);
        logic ea, eb;
        @(negedge clk);
        bus.a_valid      = av;
        bus.a_din        = ad;
        bus.b_valid      = bv;
        bus.b_din        = bd;
        bus.ram_tx_valid = tv;
        bus.ram_dout     = td;
        #1;
        model_ready(av, bv, ea, eb);
        check("a_ready",      bus.a_ready,      ea);
        check("b_ready",      bus.b_ready,      eb);
        check("busy",         bus.busy,         m_mode != 0);
        check("ram_rx_valid", bus.ram_rx_valid, e_rx_v);
        check("ram_din",      bus.ram_din,      e_din);
        check("a_dout_valid", bus.a_dout_valid, e_adv);
        check("a_dout",       bus.a_dout,       e_adout);
        check("b_dout_valid", bus.b_dout_valid, e_bdv);
        check("b_dout",       bus.b_dout,       e_bdout);
        check("timeout_err",  bus.timeout_err,  e_err);
        model_update(av, ad, bv, bd, tv, td, ea, eb);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_a_ready"},      bus.a_ready,      1'b0);
        check({tag, "_b_ready"},      bus.b_ready,      1'b0);
        check({tag, "_busy"},         bus.busy,         1'b0);
        check({tag, "_ram_rx_valid"}, bus.ram_rx_valid, 1'b0);
        check({tag, "_ram_din"},      bus.ram_din,      10'h000);
        check({tag, "_a_dout"},       bus.a_dout,       8'h00);
        check({tag, "_b_dout"},       bus.b_dout,       8'h00);
        check({tag, "_a_dout_valid"}, bus.a_dout_valid, 1'b0);
        check({tag, "_b_dout_valid"}, bus.b_dout_valid, 1'b0);
        check({tag, "_timeout_err"},  bus.timeout_err,  1'b0);
    endtask

    typedef struct {
        logic       av;
        logic [9:0] ad;
        logic       bv;
        logic [9:0] bd;
        logic       tv;
        logic [7:0] td;
        logic       x_ar;
        logic       x_br;
        logic       x_busy;
        logic       x_rx;
        logic [9:0] x_din;
    } vec_t;

    vec_t tbl[13];

    initial begin
        int first_err, err_cnt, dv_cnt;

        // Fields: a_valid a_din b_valid b_din tx_valid tx_data | a_ready b_ready busy rx_valid ram_din
        tbl[0]  = '{1'b1, 10'h205, 1'b1, 10'h101, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 10'h000};
        tbl[1]  = '{1'b0, 10'h000, 1'b1, 10'h101, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 10'h205};
        tbl[2]  = '{1'b1, 10'h300, 1'b1, 10'h101, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 10'h205};
        tbl[3]  = '{1'b0, 10'h000, 1'b1, 10'h101, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 10'h300};
        tbl[4]  = '{1'b0, 10'h000, 1'b1, 10'h101, 1'b1, 8'h5C, 1'b0, 1'b0, 1'b1, 1'b0, 10'h300};
        tbl[5]  = '{1'b0, 10'h000, 1'b1, 10'h101, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 10'h300};
        tbl[6]  = '{1'b1, 10'h1A1, 1'b1, 10'h1B1, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 10'h101};
        tbl[7]  = '{1'b1, 10'h1A2, 1'b1, 10'h1B1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 10'h1A1};
        tbl[8]  = '{1'b1, 10'h1A3, 1'b1, 10'h1B2, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1, 10'h1B1};
        tbl[9]  = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 10'h1A3};
        tbl[10] = '{1'b1, 10'h012, 1'b0, 10'h000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0, 10'h1A3};
        tbl[11] = '{1'b1, 10'h1AB, 1'b0, 10'h000, 1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1, 10'h012};
        tbl[12] = '{1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 10'h1AB};

        bus.a_valid      = 1'b0;
        bus.a_din        = '0;
        bus.b_valid      = 1'b0;
        bus.b_din        = '0;
        bus.ram_tx_valid = 1'b0;
        bus.ram_dout     = '0;

        #2 rst_n = 1'b0;
        #1 check_reset_outputs("por");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed table: tie after reset, read with B blocked, alternating ties, write pair.
        for (int i = 0; i < 13; i++) begin
            step(tbl[i].av, tbl[i].ad, tbl[i].bv, tbl[i].bd, tbl[i].tv, tbl[i].td);
            check($sformatf("tbl%0d_a_ready", i),  bus.a_ready,      tbl[i].x_ar);
            check($sformatf("tbl%0d_b_ready", i),  bus.b_ready,      tbl[i].x_br);
            check($sformatf("tbl%0d_busy", i),     bus.busy,         tbl[i].x_busy);
            check($sformatf("tbl%0d_rx_valid", i), bus.ram_rx_valid, tbl[i].x_rx);
            check($sformatf("tbl%0d_ram_din", i),  bus.ram_din,      tbl[i].x_din);
            if (i == 5) begin
                check("rd_a_dout",       bus.a_dout,       8'h5C);
                check("rd_a_dout_valid", bus.a_dout_valid, 1'b1);
                check("rd_b_dout_valid", bus.b_dout_valid, 1'b0);
            end
            if (i == 6) check("rd_a_dout_valid_once", bus.a_dout_valid, 1'b0);
        end

        // B locks with a write-address then stalls; A is waiting.
        step(1'b0, 10'h000, 1'b1, 10'h010, 1'b0, 8'h00);
        first_err = -1;
        err_cnt   = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b1, 10'h1CC, 1'b0, 10'h000, 1'b0, 8'h00);
            if (bus.timeout_err) begin
                err_cnt++;
                if (first_err < 0) first_err = k;
            end
            if (k == TO + 1) begin
                check("lock_to_busy",    bus.busy,    1'b0);
                check("lock_to_a_ready", bus.a_ready, 1'b1);
            end
            if (k == TO + 2) begin
                check("lock_to_a_rx",  bus.ram_rx_valid, 1'b1);
                check("lock_to_a_din", bus.ram_din,      10'h1CC);
            end
        end
        check("lock_to_when",   32'(first_err), 32'(TO + 1));
        check("lock_to_pulses", 32'(err_cnt),   32'd1);

        // A opens a read that the RAM never answers; a late return must be ignored.
        step(1'b1, 10'h3FF, 1'b0, 10'h000, 1'b0, 8'h00);
        first_err = -1;
        err_cnt   = 0;
        dv_cnt    = 0;
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 10'h000, 1'b0, 10'h000, 1'(k == TO + 3), 8'hEE);
            if (bus.timeout_err) begin
                err_cnt++;
                if (first_err < 0) first_err = k;
            end
            if (bus.a_dout_valid || bus.b_dout_valid) dv_cnt++;
        end
        check("rd_to_when",   32'(first_err), 32'(TO + 1));
        check("rd_to_pulses", 32'(err_cnt),   32'd1);
        check("rd_to_no_dout", 32'(dv_cnt),   32'd0);

        // A transfer in the cycle the counter would expire keeps the lock.
        err_cnt = 0;
        step(1'b1, 10'h0AA, 1'b0, 10'h000, 1'b0, 8'h00);
        for (int k = 0; k < 2 * TO + 2; k++) begin
            step(1'(k == TO - 1), 10'h0BB, 1'b0, 10'h000, 1'b0, 8'h00);
            if (bus.timeout_err) err_cnt++;
            if (k == TO) check("race_busy", bus.busy, 1'b1);
        end
        check("race_errs", 32'(err_cnt), 32'd1);
        step(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 8'h00);

        // Reset while B holds the lock with a RAM command still on the wire.
        step(1'b0, 10'h000, 1'b1, 10'h0A0, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        check("pre_rst_busy", bus.busy,         1'b1);
        check("pre_rst_rx",   bus.ram_rx_valid, 1'b1);
        bus.b_valid = 1'b0;
        rst_n       = 1'b0;
        #1 check_reset_outputs("mid_rst");
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 10'h000, 1'b0, 10'h000, 1'b1, 8'h77);
        step(1'b1, 10'h1A5, 1'b1, 10'h1B5, 1'b0, 8'h00);
        check("post_rst_tie_a", bus.a_ready, 1'b1);
        check("post_rst_tie_b", bus.b_ready, 1'b0);

        // Random traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            logic       av, bv, tv;
            logic [9:0] ad, bd;
            logic [7:0] td;
            av = 1'($urandom_range(0, 99) < 55);
            bv = 1'($urandom_range(0, 99) < 55);
            tv = 1'($urandom_range(0, 99) < 25);
            ad = 10'($urandom);
            bd = 10'($urandom);
            td = 8'($urandom);
            step(av, ad, bv, bd, tv, td);
        end

        step(1'b0, 10'h000, 1'b0, 10'h000, 1'b0, 8'h00);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
